// File: rtl/sap_ctrl_seq_if.sv
// Control interface between the SAP sequencer and the datapath it steers.
// master = sequencer side (drives strobes), slave = datapath side (drives IR opcode and ZF).
interface sap_ctrl_seq_if #(
   parameter int OPC_W = 3
);
   logic [OPC_W-1:0] OPCODE;
   logic             ZF;
   logic             CP;
   logic             EP;
   logic             LM;
   logic             CE;
   logic             LI;
   logic             EI;
   logic             LA;
   logic             EA;
   logic             LB;
   logic             SU;
   logic             EU;
   logic             LO;
   logic             LP;
   logic             HALT;
   logic [5:0]       T_STATE;

   modport master (
      input  OPCODE, ZF,
      output CP, EP, LM, CE, LI, EI, LA, EA, LB, SU, EU, LO, LP, HALT, T_STATE
   );

   modport slave (
      output OPCODE, ZF,
      input  CP, EP, LM, CE, LI, EI, LA, EA, LB, SU, EU, LO, LP, HALT, T_STATE
   );
endinterface

// File: rtl/sap_ctrl_seq.sv
// SAP controller/sequencer: one-hot T1..T6 ring plus sticky halt, with
// opcode-qualified Moore decode of all datapath strobes.
module sap_ctrl_seq #(
   parameter int OPC_W    = 3,
   parameter bit FAST_END = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   sap_ctrl_seq_if.master bus
);

   typedef struct packed {
      logic cp;
      logic ep;
      logic lm;   // active-low MAR load
      logic ce;
      logic li;
      logic ei;
      logic la;
      logic ea;
      logic lb;
      logic su;
      logic eu;
      logic lo;
      logic lp;
   } ctrl_t;

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T4 = 6'b001000;

   localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(7);

   // idle value of the control word: everything off, LM high
   localparam ctrl_t CTRL_IDLE = '{lm: 1'b1, default: 1'b0};

   logic [5:0] ring_q, ring_d;
   logic       halt_q, halt_d;
   logic       short_op;
   logic       ring_ok;
   ctrl_t      ctrl;

   // instructions with nothing to do after T4 (eligible for early wrap)
   assign short_op = (bus.OPCODE == OP_OUT) || (bus.OPCODE == OP_JMP) ||
                     (bus.OPCODE == OP_JZ)  || (bus.OPCODE == OP_NOP);
   assign ring_ok  = $onehot(ring_q);

   // state register: ring and halt flag, async clear to T1 / running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ring_q <= T1;
         halt_q <= 1'b0;
      end else begin
         ring_q <= ring_d;
         halt_q <= halt_d;
      end
   end

   // next-state: rotate ring, early wrap, halt capture, illegal-pattern recovery
   always_comb begin
      ring_d = ring_q;
      halt_d = halt_q;
      if (halt_q) begin
         // frozen at T4 until reset; also repairs a corrupted ring while halted
         ring_d = T4;
      end else if (!ring_ok) begin
         ring_d = T1;
      end else if (ring_q[3] && (bus.OPCODE == OP_HLT)) begin
         halt_d = 1'b1;
         ring_d = T4;
      end else if (ring_q[3] && FAST_END && short_op) begin
         ring_d = T1;
      end else begin
         ring_d = {ring_q[4:0], ring_q[5]};
      end
   end

   // output decode: fetch T1-T3, opcode-qualified execute T4-T6; idle in reset/halt
   always_comb begin
      ctrl = CTRL_IDLE;
      // rst gates the outputs directly so nothing leaks while the ring is forced to T1
      if (!rst && !halt_q && ring_ok) begin
         if (ring_q[0]) begin
            ctrl.ep = 1'b1;
            ctrl.lm = 1'b0;
         end else if (ring_q[1]) begin
            ctrl.cp = 1'b1;
         end else if (ring_q[2]) begin
            ctrl.ce = 1'b1;
            ctrl.li = 1'b1;
         end else if (ring_q[3]) begin
            case (bus.OPCODE)
               OP_LDA, OP_ADD, OP_SUB: begin
                  ctrl.ei = 1'b1;
                  ctrl.lm = 1'b0;
               end
               OP_OUT: begin
                  ctrl.ea = 1'b1;
                  ctrl.lo = 1'b1;
               end
               OP_JMP: begin
                  ctrl.ei = 1'b1;
                  ctrl.lp = 1'b1;
               end
               OP_JZ: begin
                  ctrl.ei = 1'b1;
                  ctrl.lp = bus.ZF;
               end
               default: ;
            endcase
         end else if (ring_q[4]) begin
            case (bus.OPCODE)
               OP_LDA: begin
                  ctrl.ce = 1'b1;
                  ctrl.la = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl.ce = 1'b1;
                  ctrl.lb = 1'b1;
               end
               default: ;
            endcase
         end else begin
            if ((bus.OPCODE == OP_ADD) || (bus.OPCODE == OP_SUB)) begin
               ctrl.eu = 1'b1;
               ctrl.la = 1'b1;
               ctrl.su = (bus.OPCODE == OP_SUB);
            end
         end
      end
   end

   assign bus.CP      = ctrl.cp;
   assign bus.EP      = ctrl.ep;
   assign bus.LM      = ctrl.lm;
   assign bus.CE      = ctrl.ce;
   assign bus.LI      = ctrl.li;
   assign bus.EI      = ctrl.ei;
   assign bus.LA      = ctrl.la;
   assign bus.EA      = ctrl.ea;
   assign bus.LB      = ctrl.lb;
   assign bus.SU      = ctrl.su;
   assign bus.EU      = ctrl.eu;
   assign bus.LO      = ctrl.lo;
   assign bus.LP      = ctrl.lp;
   assign bus.HALT    = halt_q;
   assign bus.T_STATE = ring_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Bench for sap_ctrl_seq: two instances (FAST_END=0 and 1) share stimulus and are
// each compared every cycle against an instruction-level reference model.
module tb_sap_ctrl_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] op  = 3'd6;
   logic       zf  = 1'b0;

   int cmp_cnt = 0;
   int err_cnt = 0;

   // model state per instance: T number 1..6 and halted flag
   int t  [2];
   bit hl [2];
   bit fast [2];

   always #5 clk = ~clk;

   sap_ctrl_seq_if #(.OPC_W(3)) bus0 ();
   sap_ctrl_seq_if #(.OPC_W(3)) bus1 ();

   sap_ctrl_seq #(.OPC_W(3), .FAST_END(1'b0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
   sap_ctrl_seq #(.OPC_W(3), .FAST_END(1'b1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

   assign bus0.OPCODE = op;
   assign bus1.OPCODE = op;
   assign bus0.ZF     = zf;
   assign bus1.ZF     = zf;

   // observed control words, order {CP,EP,LM,CE,LI,EI,LA,EA,LB,SU,EU,LO,LP}
   logic [12:0] obs [2];
   logic [5:0]  obs_t [2];
   logic        obs_h [2];
   logic [4:0]  obs_drv [2];
   assign obs[0] = {bus0.CP, bus0.EP, bus0.LM, bus0.CE, bus0.LI, bus0.EI, bus0.LA,
                    bus0.EA, bus0.LB, bus0.SU, bus0.EU, bus0.LO, bus0.LP};
   assign obs[1] = {bus1.CP, bus1.EP, bus1.LM, bus1.CE, bus1.LI, bus1.EI, bus1.LA,
                    bus1.EA, bus1.LB, bus1.SU, bus1.EU, bus1.LO, bus1.LP};
   assign obs_t[0]   = bus0.T_STATE;
   assign obs_t[1]   = bus1.T_STATE;
   assign obs_h[0]   = bus0.HALT;
   assign obs_h[1]   = bus1.HALT;
   assign obs_drv[0] = {bus0.EP, bus0.CE, bus0.EI, bus0.EA, bus0.EU};
   assign obs_drv[1] = {bus1.EP, bus1.CE, bus1.EI, bus1.EA, bus1.EU};

   // micro-op table per instruction step
   function automatic logic [12:0] exp_ctrl(int ts, bit h, logic [2:0] o, logic z, logic r);
      logic cp, ep, lm, ce, li, ei, la, ea, lb, su, eu, lo, lp;
      {cp, ep, ce, li, ei, la, ea, lb, su, eu, lo, lp} = '0;
      lm = 1'b1;
      if (!r && !h) begin
         case (ts)
            1: begin ep = 1; lm = 0; end
            2: cp = 1;
            3: begin ce = 1; li = 1; end
            4: case (o)
                  3'd0, 3'd1, 3'd2: begin ei = 1; lm = 0; end
                  3'd3: begin ea = 1; lo = 1; end
                  3'd4: begin ei = 1; lp = 1; end
                  3'd5: begin ei = 1; lp = z; end
                  default: ;
               endcase
            5: case (o)
                  3'd0: begin ce = 1; la = 1; end
                  3'd1, 3'd2: begin ce = 1; lb = 1; end
                  default: ;
               endcase
            6: if (o == 3'd1 || o == 3'd2) begin eu = 1; la = 1; su = (o == 3'd2); end
            default: ;
         endcase
      end
      return {cp, ep, lm, ce, li, ei, la, ea, lb, su, eu, lo, lp};
   endfunction

   task automatic check_all(string tag);
      for (int k = 0; k < 2; k++) begin
         logic [12:0] ec;
         logic [5:0]  et;
         ec = exp_ctrl(t[k], hl[k], op, zf, rst);
         et = 6'b000001 << (t[k] - 1);
         cmp_cnt++;
         assert (obs[k] === ec) else begin
            err_cnt++;
            $error("FAIL %s ctrl dut%0d: observed %b expected %b", tag, k, obs[k], ec);
         end
         cmp_cnt++;
         assert (obs_t[k] === et) else begin
            err_cnt++;
            $error("FAIL %s tstate dut%0d: observed %b expected %b", tag, k, obs_t[k], et);
         end
         cmp_cnt++;
         assert (obs_h[k] === hl[k]) else begin
            err_cnt++;
            $error("FAIL %s halt dut%0d: observed %b expected %b", tag, k, obs_h[k], hl[k]);
         end
         cmp_cnt++;
         assert ($onehot(obs_t[k]) === 1'b1) else begin
            err_cnt++;
            $error("FAIL %s onehot dut%0d: observed %b expected one bit set", tag, k, obs_t[k]);
         end
         cmp_cnt++;
         assert (($countones(obs_drv[k]) <= 1) === 1'b1) else begin
            err_cnt++;
            $error("FAIL %s busdrv dut%0d: observed %b expected at most one", tag, k, obs_drv[k]);
         end
      end
   endtask

   // advance the model across one rising edge using the inputs present at that edge
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            t[k] = 1; hl[k] = 0;
         end else if (hl[k]) begin
            t[k] = 4;
         end else if (t[k] == 4 && op == 3'd7) begin
            hl[k] = 1;
         end else if (t[k] == 4 && fast[k] && (op == 3'd3 || op == 3'd4 || op == 3'd5 || op == 3'd6)) begin
            t[k] = 1;
         end else begin
            t[k] = (t[k] == 6) ? 1 : t[k] + 1;
         end
      end
   endtask

   // check at the falling edge, then cross the rising edge
   task automatic step(int n, string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_all(tag);
         @(posedge clk);
         model_edge();
         #1;
      end
   endtask

   task automatic raise_rst(string tag);
      rst = 1'b1;
      t[0] = 1; t[1] = 1; hl[0] = 0; hl[1] = 0;
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      raise_rst("rst");
      step(1, "rst_hold");
      rst = 1'b0;
   endtask

   initial begin
      fast[0] = 0; fast[1] = 1;
      t[0] = 1; t[1] = 1; hl[0] = 0; hl[1] = 0;
      rst = 1'b1; op = 3'd6; zf = 1'b0;
      #1;
      step(2, "reset_state");
      rst = 1'b0;
      step(7, "nop_fetch");

      do_reset(); op = 3'd1; step(6, "add");
      do_reset(); op = 3'd2; step(6, "sub");
      do_reset(); op = 3'd5; zf = 1'b0; step(6, "jz_zf0");
      do_reset(); op = 3'd5; zf = 1'b1; step(6, "jz_zf1");
      do_reset(); op = 3'd3; step(6, "out");
      do_reset(); op = 3'd4; zf = 1'b0; step(6, "jmp");

      do_reset(); op = 3'd7; step(24, "hlt");
      op = 3'd1;
      step(2, "hlt_opchg");
      raise_rst("hlt_rst");
      rst = 1'b0;
      step(2, "after_hlt");

      // reset arriving in the middle of LDA T5
      do_reset(); op = 3'd0; step(4, "lda");
      #2;
      check_all("lda_t5");
      raise_rst("lda_t5_rst");
      rst = 1'b0;
      step(3, "lda_recover");

      // random opcode/flag traffic, with occasional resets to leave halt
      do_reset();
      for (int i = 0; i < 1000; i++) begin
         op = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
         zf = 1'($urandom_range(0, 1));
         if (hl[0] && hl[1] && $urandom_range(0, 3) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 99) == 0) begin
            raise_rst("rand_rst");
            rst = 1'b0;
         end
         step(1, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/sap_ctrl_seq.md
Name: sap_ctrl_seq

Overview:
Controller/sequencer for the 5-bit-address SAP datapath. It sits directly upstream of the program counter and memory address register, and generates their control strobes: EP, CP and active-low LM. It also drives every other datapath enable from a one-hot T-state ring counter and the 3-bit opcode held in the instruction register. It is a Moore-style sequencer with opcode-qualified decode, plus a sticky halt state.

Parameters:
OPC_W, 3, opcode width; the instruction is {opcode[2:0], operand[4:0]}.
FAST_END, 0, when 1, an instruction with no T5/T6 micro-ops returns to T1 after T4.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
OPCODE  input  3  IR[7:5]; valid from T4 onward
ZF  input  1  accumulator zero flag, sampled in T4 of JZ
CP  output  1  PC increment enable
EP  output  1  PC drive-bus enable
LM  output  1  MAR load, ACTIVE-LOW (MAR loads when LM=0)
CE  output  1  RAM drive-bus enable
LI  output  1  IR load
EI  output  1  IR operand drive-bus
LA  output  1  A register load
EA  output  1  A drive-bus
LB  output  1  B register load
SU  output  1  ALU subtract select
EU  output  1  ALU drive-bus
LO  output  1  output register load
LP  output  1  PC parallel load (jump)
HALT  output  1  processor halted
T_STATE  output  6  one-hot ring state, bit0 = T1

Behaviour:
- Reset: asynchronous; while rst=1, T_STATE=6'b000001 and HALT=0. All control outputs are forced inactive while rst=1: active-high outputs 0, LM=1. First T1 decode occurs in the first cycle after rst falls.
- Ring: one-hot, advances T1->T2->...->T6->T1 each clk. With FAST_END=1, the ring goes T4->T1 for OUT, JMP, JZ and NOP. LDA always runs to T6.
- All outputs are combinational from the registered ring, HALT and OPCODE. Exactly one ring bit is set at all times; illegal patterns recover to T1 on the next edge.
- Fetch, independent of opcode:
  - T1: EP=1, LM=0.
  - T2: CP=1.
  - T3: CE=1, LI=1.
- Execute, opcode 000 LDA: T4 EI=1, LM=0; T5 CE=1, LA=1; T6 none.
- Execute, opcode 001 ADD: T4 EI=1, LM=0; T5 CE=1, LB=1; T6 EU=1, LA=1.
- Execute, opcode 010 SUB: same as ADD, with SU=1 in T6 alongside EU and LA.
- Execute, opcode 011 OUT: T4 EA=1, LO=1.
- Execute, opcode 100 JMP: T4 EI=1, LP=1.
- Execute, opcode 101 JZ: T4 EI=1, LP=ZF (ZF sampled combinationally in T4 only).
- Execute, opcode 110 NOP: no micro-ops.
- Execute, opcode 111 HLT:
  - T4 asserts no micro-ops; on the T4 clock edge HALT becomes 1 and the ring freezes at T4.
  - While HALT=1, all control outputs are inactive (LM=1) and T_STATE holds 6'b001000.
  - Only rst clears HALT.
- At most one bus driver (EP, CE, EI, EA, EU) is active in any cycle. The bench asserts this.
- Reset asserted mid-instruction: the ring returns to T1 immediately and asynchronously, and outputs go inactive in the same cycle. No partial micro-op may complete after rst rises.
- OPCODE changes during T1–T3 have no effect on outputs.

Test Plan:
- Reset release, then 3 clocks, OPCODE=110 → T1: EP=1, LM=0. T2: CP=1. T3: CE=1, LI=1. T4–T6: all inactive, LM=1. The 7th cycle is T1 again.
- ADD (001) → T4 EI=1, LM=0. T5 CE=1, LB=1. T6 EU=1, LA=1, SU=0. Repeat with SUB (010) → T6 additionally SU=1.
- JZ (101) with ZF=0 → LP=0 in T4. With ZF=1 → LP=1 and EI=1 in T4. With FAST_END=1, the cycle after T4 is T1 (T_STATE=6'b000001).
- HLT (111) → after the T4 edge, HALT=1 and T_STATE=6'b001000, stable for 20 clocks with all outputs inactive. Asserting rst → HALT=0, T_STATE=6'b000001.
- Assert rst asynchronously in the middle of T5 of LDA → CE and LA drop in the same cycle, LM=1. After release, T1 executes with EP=1, LM=0.
- Random OPCODE/ZF for 1000 cycles → one-hot T_STATE always holds, and at most one bus driver is active per cycle.
